// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, reads instruction memory over a req/ack handshake,
// latches the returned word into the IR and offers it to decode with valid/ready.
// On retire the PC advances by 4 or is redirected by a j / jr from control.
module instruction_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    // instruction memory
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    // decode handshake
    output logic              instr_valid,
    input  logic              instr_ready,
    // decoded fields
    output logic [5:0]        Opcode,
    output logic [5:0]        Function,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [15:0]       imm16,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    // redirect from control
    input  logic              jump_en,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4_q;
    logic [31:0]       ir_q, ir_d;
    logic              req_q, valid_q;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] pc_redirect;

    // Retire target: sequential, absolute j inside the current 256 MB region, or jr.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        pc_redirect = pc_plus4_q;
        if (jump_en) begin
            if (jump_reg) begin
                pc_redirect = {jr_target[ADDR_W-1:2], 2'b00};
            end else begin
                pc_redirect = {pc_plus4_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
            end
        end
    end

    // Next-state logic: fetch handshake in REQ, retire handshake in HOLD.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        misalign_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_d       = pc_redirect;
                    state_d    = ST_REQ;
                    misalign_d = jump_en && jump_reg && (jr_target[1:0] != 2'b00);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset overrides any handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + PC_STEP;
            ir_q       <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_d + PC_STEP;
            ir_q       <= ir_d;
            req_q      <= (state_d == ST_REQ);
            valid_q    <= (state_d == ST_HOLD);
            misalign_q <= misalign_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign misalign    = misalign_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_plus4_q;

    assign Opcode      = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign Function    = ir_q[5:0];
    assign imm16       = ir_q[15:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a memory responder with chosen ack
// latency, a scoreboard of fetched words, and a reference model of the next PC.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  Opcode, Function;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] pc_out, pc_plus4;
    logic        jump_en, jump_reg;
    logic [31:0] jr_target;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Opcode     (Opcode),
        .Function   (Function),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm16      (imm16),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .jump_en    (jump_en),
        .jump_reg   (jump_reg),
        .jr_target  (jr_target),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC model taken from the redirect rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                               input logic jen, input logic jreg,
                                               input logic [31:0] jtgt);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (!jen)      return seq;
        else if (jreg) return {jtgt[31:2], 2'b00};
        else           return {seq[31:28], word[25:0], 2'b00};
    endfunction

    // Wait (bounded) for a fetch request to appear.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    // One complete fetch/hold/retire transaction.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                            input int lat, input int hold, input bit stray_ack,
                            input logic jen, input logic jreg, input logic [31:0] jtgt,
                            output logic [31:0] next_addr);
        bit   ok;
        exp_t e;
        logic exp_mis;
        next_addr = exp_addr;
        wait_req(ok);
        if (!ok) return;
        check("req_addr", imem_addr, exp_addr);
        for (int i = 0; i < lat; i++) begin
            tick();
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("valid_before_ack", {31'd0, instr_valid}, 32'd0);
            check("addr_stable", imem_addr, exp_addr);
            check("misalign_idle", {31'd0, misalign}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        e.pc   = exp_addr;
        e.word = word;
        sb_q.push_back(e);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        check("req_drop", {31'd0, imem_req}, 32'd0);
        e = sb_q.pop_front();
        check("opcode",   {26'd0, Opcode},   {26'd0, e.word[31:26]});
        check("function", {26'd0, Function}, {26'd0, e.word[5:0]});
        check("rs",       {27'd0, rs},       {27'd0, e.word[25:21]});
        check("rt",       {27'd0, rt},       {27'd0, e.word[20:16]});
        check("rd",       {27'd0, rd},       {27'd0, e.word[15:11]});
        check("imm16",    {16'd0, imm16},    {16'd0, e.word[15:0]});
        check("pc_out",   pc_out,            e.pc);
        check("pc_plus4", pc_plus4,          e.pc + 32'd4);
        for (int i = 0; i < hold; i++) begin
            if (stray_ack && i == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = ~word;
            end
            tick();
            imem_ack = 1'b0;
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_imm16", {16'd0, imm16}, {16'd0, e.word[15:0]});
            check("hold_opcode", {26'd0, Opcode}, {26'd0, e.word[31:26]});
            check("hold_pc", pc_out, e.pc);
        end
        instr_ready = 1'b1;
        jump_en     = jen;
        jump_reg    = jreg;
        jr_target   = jtgt;
        tick();
        instr_ready = 1'b0;
        jump_en     = 1'b0;
        jump_reg    = 1'b0;
        jr_target   = 32'hA5A5_A5A7;
        next_addr = model_next(e.pc, e.word, jen, jreg, jtgt);
        exp_mis   = jen && jreg && (jtgt[1:0] != 2'b00);
        check("retire_valid", {31'd0, instr_valid}, 32'd0);
        check("retire_req", {31'd0, imem_req}, 32'd1);
        check("next_addr", imem_addr, next_addr);
        check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_opcode", {26'd0, Opcode}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] nxt;
        bit          ok;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        jump_en     = 1'b0;
        jump_reg    = 1'b0;
        jr_target   = 32'd0;
        #1;
        do_reset();

        // add $10,$8,$9 with ack one cycle after request; spot-check known fields
        do_fetch(32'h0, 32'h0109_5020, 1, 1, 1'b0, 1'b0, 1'b0, 32'd0, nxt);
        check("first_next", nxt, 32'h4);

        // three sequential words, ack latency 0/2/5, stray ack while holding
        do_reset();
        do_fetch(32'h0, 32'h2108_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, nxt);
        do_fetch(nxt,   32'h8C43_0010, 2, 3, 1'b1, 1'b0, 1'b0, 32'd0, nxt);
        do_fetch(nxt,   32'hAC64_FFFC, 5, 1, 1'b0, 1'b0, 1'b0, 32'd0, nxt);
        check("seq_end", nxt, 32'hC);

        // jr to 0x0040_0010, then j from there
        do_fetch(nxt, 32'h0320_0008, 1, 0, 1'b0, 1'b1, 1'b1, 32'h0040_0010, nxt);
        do_fetch(nxt, 32'h0810_0008, 0, 0, 1'b0, 1'b1, 1'b0, 32'd0, nxt);
        check("j_target", imem_addr, 32'h0040_0020);

        // misaligned jr: rounded target, misalign for exactly one cycle
        do_fetch(nxt, 32'h03E0_0008, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_1236, nxt);
        check("jr_target", imem_addr, 32'h0000_1234);
        tick();
        check("misalign_pulse_end", {31'd0, misalign}, 32'd0);

        // PC wrap from the top of the address space
        do_fetch(nxt, 32'h0000_0000, 2, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, nxt);
        do_fetch(nxt, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, nxt);
        check("wrap_addr", imem_addr, 32'h0);

        // reset during an outstanding request with an ack in the same cycle
        wait_req(ok);
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        reset      = 1'b1;
        tick();
        imem_ack = 1'b0;
        reset    = 1'b0;
        check("rstack_valid", {31'd0, instr_valid}, 32'd0);
        check("rstack_req", {31'd0, imem_req}, 32'd0);
        check("rstack_opcode", {26'd0, Opcode}, 32'd0);
        check("rstack_imm16", {16'd0, imm16}, 32'd0);
        do_fetch(32'h0, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, nxt);
        check("refetch_next", nxt, 32'h4);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
